// File: rtl/ghash_serial_core.sv
// ghash_serial_core: iterative GF(2^128) GHASH engine for AES-GCM.
// Shift-and-add multiplier, BITS_PER_CYCLE multiplier bits per clock.
module ghash_serial_core #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] hash_key_H,
    input  logic [127:0] data_in,
    input  logic         data_valid,
    input  logic         finalize,
    input  logic [63:0]  ad_bits,
    input  logic [63:0]  ct_bits,
    output logic         ready,
    output logic         done,
    output logic [127:0] hash_out
);
    localparam int MUL_CYCLES = 128 / BITS_PER_CYCLE;
    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
    localparam logic [127:0] R = {8'he1, 120'd0};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINAL,
        DONE
    } state_t;

    state_t         state;
    logic [127:0]   h;
    logic [127:0]   acc;
    logic [127:0]   x;
    logic [127:0]   z;
    logic [127:0]   v;
    logic [CW-1:0]  cnt;
    logic [127:0]   x_n;
    logic [127:0]   z_n;
    logic [127:0]   v_n;

    assign hash_out = acc;

    // BITS_PER_CYCLE unrolled multiplier iterations (MSB of X first)
    always_comb begin
        x_n = x;
        z_n = z;
        v_n = v;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (x_n[127]) z_n = z_n ^ v_n;
            v_n = {1'b0, v_n[127:1]} ^ (v_n[0] ? R : '0);
            x_n = {x_n[126:0], 1'b0};
        end
    end

    // Control FSM and datapath registers; start aborts any multiply
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            h     <= '0;
            acc   <= '0;
            x     <= '0;
            z     <= '0;
            v     <= '0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else if (start) begin
            state <= IDLE;
            h     <= hash_key_H;
            acc   <= '0;
            x     <= '0;
            z     <= '0;
            v     <= '0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_valid) begin
                        x     <= acc ^ data_in;
                        z     <= '0;
                        v     <= h;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= BUSY;
                    end else if (finalize) begin
                        x     <= acc ^ {ad_bits, ct_bits};
                        z     <= '0;
                        v     <= h;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= FINAL;
                    end
                end
                BUSY, FINAL: begin
                    x <= x_n;
                    z <= z_n;
                    v <= v_n;
                    if (cnt == LAST) begin
                        acc <= z_n;
                        if (state == BUSY) begin
                            state <= IDLE;
                            ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ghash_serial_core.sv
// tb_ghash_serial_core: randomized and directed bench for ghash_serial_core.
// Message-level GHASH model with per-cycle output comparison.
module tb_ghash_serial_core;
    localparam int MUL = 128;
    localparam logic [127:0] TC_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] TC_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TC_MID = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] TC_FIN = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [127:0] ONE    = 128'h80000000000000000000000000000000;
    localparam logic [127:0] IDV    = 128'h0123456789abcdeffedcba9876543210;

    logic clk = 1'b0;
    logic reset;
    logic start, data_valid, finalize;
    logic [127:0] hash_key_H, data_in;
    logic [63:0] ad_bits, ct_bits;
    logic ready, done;
    logic [127:0] hash_out;

    logic start8, dv8, fin8;
    logic [127:0] key8, din8;
    logic [63:0] ad8, ct8;
    logic ready8, done8;
    logic [127:0] hash8;

    int passed = 0;
    int total = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ghash_serial_core u_dut (
        .clk(clk), .reset(reset), .start(start), .hash_key_H(hash_key_H),
        .data_in(data_in), .data_valid(data_valid), .finalize(finalize),
        .ad_bits(ad_bits), .ct_bits(ct_bits), .ready(ready), .done(done),
        .hash_out(hash_out)
    );

    ghash_serial_core #(.BITS_PER_CYCLE(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .hash_key_H(key8),
        .data_in(din8), .data_valid(dv8), .finalize(fin8),
        .ad_bits(ad8), .ct_bits(ct8), .ready(ready8), .done(done8),
        .hash_out(hash8)
    );

    // GF(2^128) product in GCM bit order, straight from the definition
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] zz;
        logic [127:0] vv;
        zz = '0;
        vv = b;
        for (int i = 0; i < 128; i++) begin
            if (a[127-i]) zz = zz ^ vv;
            vv = vv[0] ? ((vv >> 1) ^ {8'he1, 120'd0}) : (vv >> 1);
        end
        return zz;
    endfunction

    // Behavioural model: accumulator, key, and a busy countdown per multiply
    logic [127:0] m_acc, m_h, m_pend;
    logic m_ready, m_done, m_fin;
    int m_left;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc <= '0; m_h <= '0; m_pend <= '0;
            m_ready <= 1'b1; m_done <= 1'b0; m_fin <= 1'b0; m_left <= 0;
        end else if (start) begin
            m_h <= hash_key_H; m_acc <= '0;
            m_ready <= 1'b1; m_done <= 1'b0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_acc <= m_pend;
                if (m_fin) m_done <= 1'b1;
                else m_ready <= 1'b1;
            end
        end else if (m_ready && data_valid) begin
            m_pend <= gf_mul(m_acc ^ data_in, m_h);
            m_left <= MUL; m_ready <= 1'b0; m_fin <= 1'b0;
        end else if (m_ready && finalize) begin
            m_pend <= gf_mul(m_acc ^ {ad_bits, ct_bits}, m_h);
            m_left <= MUL; m_ready <= 1'b0; m_fin <= 1'b1;
        end
    end

    // Per-cycle compare of the DUT against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            total++;
            if (ready === m_ready && done === m_done && hash_out === m_acc)
                passed++;
            else
                $display("FAIL cycle t=%0t: ready %b/%b done %b/%b hash %h/%h",
                         $time, ready, m_ready, done, m_done, hash_out, m_acc);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (!ready) chk("wait_ready timeout", 128'(ready), 128'd1);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        hash_key_H = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d);
        wait_ready(300);
        data_valid = 1'b1; data_in = d;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic send_final(input logic [63:0] a, input logic [63:0] c);
        wait_ready(300);
        finalize = 1'b1; ad_bits = a; ct_bits = c;
        @(negedge clk);
        finalize = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (!ready && !done && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic tc2_seq(input string tag);
        int n;
        pulse_start(TC_H);
        send_block(TC_C);
        busy_len(n);
        chk({tag, " block latency"}, 128'(n), 128'(MUL));
        chk({tag, " mid hash"}, hash_out, TC_MID);
        send_final(64'd0, 64'd128);
        busy_len(n);
        chk({tag, " final latency"}, 128'(n), 128'(MUL));
        chk({tag, " final hash"}, hash_out, TC_FIN);
        chk({tag, " done"}, 128'(done), 128'd1);
    endtask

    initial begin
        int n;
        int acc_n;
        logic [127:0] r;
        reset = 1'b1;
        start = 0; data_valid = 0; finalize = 0;
        hash_key_H = '0; data_in = '0; ad_bits = '0; ct_bits = '0;
        start8 = 0; dv8 = 0; fin8 = 0; key8 = '0; din8 = '0; ad8 = '0; ct8 = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", 128'(ready), 128'd1);
        chk("reset done", 128'(done), 128'd0);
        chk("reset hash", hash_out, 128'd0);
        reset = 1'b0;
        chk_en = 1;

        chk("model C*H", gf_mul(TC_C, TC_H), TC_MID);
        chk("model len", gf_mul(TC_MID ^ 128'd128, TC_H), TC_FIN);
        chk("model identity", gf_mul(IDV, ONE), IDV);

        pulse_start(ONE);
        send_block(IDV);
        busy_len(n);
        chk("identity latency", 128'(n), 128'(MUL));
        chk("identity hash", hash_out, IDV);

        tc2_seq("tc2");

        pulse_start({$urandom, $urandom, $urandom, $urandom});
        send_final(64'd0, 64'd0);
        busy_len(n);
        chk("empty hash", hash_out, 128'd0);
        chk("empty done", 128'(done), 128'd1);
        data_valid = 1'b1; finalize = 1'b1; data_in = '1;
        repeat (5) @(negedge clk);
        data_valid = 1'b0; finalize = 1'b0;
        chk("done ignores inputs", {126'd0, ready, done}, 128'd1);

        pulse_start({$urandom, $urandom, $urandom, $urandom});
        acc_n = 0;
        data_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            if (ready) acc_n++;
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk("handshake accepts", 128'(acc_n), 128'd4);
        send_final(64'($urandom), 64'($urandom));
        busy_len(n);
        chk("handshake done", 128'(done), 128'd1);

        pulse_start({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 3000; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            ad_bits = 64'($urandom); ct_bits = 64'($urandom);
            data_valid = ($urandom_range(0, 3) == 0);
            finalize = ($urandom_range(0, 40) == 0);
            hash_key_H = {$urandom, $urandom, $urandom, $urandom};
            start = ($urandom_range(0, 700) == 0);
            @(negedge clk);
        end
        start = 0; data_valid = 0; finalize = 0;

        r = {$urandom, $urandom, $urandom, $urandom};
        pulse_start(r);
        send_block(~r);
        repeat (49) @(negedge clk);
        pulse_start(TC_H);
        chk("abort ready", 128'(ready), 128'd1);
        chk("abort done", 128'(done), 128'd0);
        chk("abort hash", hash_out, 128'd0);
        chk("abort model agrees", 128'(m_ready), 128'd1);
        tc2_seq("abort tc2");

        pulse_start(TC_H);
        send_block(TC_C);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async ready", 128'(ready), 128'd1);
        chk("async done", 128'(done), 128'd0);
        chk("async hash", hash_out, 128'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        key8 = TC_H; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; dv8 = 1'b1; din8 = TC_C;
        @(negedge clk);
        dv8 = 1'b0;
        n = 0;
        while (!ready8 && n < 300) begin n++; @(negedge clk); end
        chk("bpc8 block latency", 128'(n), 128'd16);
        chk("bpc8 mid hash", hash8, TC_MID);
        fin8 = 1'b1; ad8 = 64'd0; ct8 = 64'd128;
        @(negedge clk);
        fin8 = 1'b0;
        n = 0;
        while (!done8 && n < 300) begin n++; @(negedge clk); end
        chk("bpc8 final latency", 128'(n), 128'd16);
        chk("bpc8 final hash", hash8, TC_FIN);
        chk("bpc8 ready low", 128'(ready8), 128'd0);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
